// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounces N raw push-buttons and detects presses.
// It keeps a toggle bit per button and latches presses as pending.
// Pending presses are delivered one at a time on a valid/ready event port.
// A round-robin pointer picks which pending button is offered next.
module button_event_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_button,
  input  logic           i_evt_ready,
  output logic           o_evt_valid,
  output logic [IDW-1:0] o_evt_id,
  output logic [N-1:0]   o_toggle_state,
  output logic [N-1:0]   o_pending,
  output logic [N-1:0]   o_overflow
);

  localparam int          IDX_W   = IDW + 1;
  localparam logic [7:0]  CNT_MAX = 8'(DEBOUNCE - 1);
  localparam logic [IDX_W-1:0] N_W = IDX_W'(N);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  logic [N-1:0]   r_s;
  logic [N-1:0]   r_db;
  logic [7:0]     r_cnt [N];
  logic [N-1:0]   r_toggle;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   r_overflow;
  state_t         r_state;
  logic           r_evt_valid;
  logic [IDW-1:0] r_evt_id;
  logic [IDW-1:0] r_ptr;

  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_clr;
  logic           w_hs;
  logic           w_found;
  logic [IDW-1:0] w_grant_id;
  logic [IDW-1:0] w_next_ptr;

  // A press is the debounced 0->1 update about to happen at this edge.
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < N; i++) begin
      w_rise[i] = r_s[i] & ~r_db[i] & (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_hs = (r_state == ST_OFFER) & i_evt_ready;

  // One-hot clear of the delivered button's pending bit on a handshake.
  always_comb begin
    w_clr = '0;
    if (w_hs) begin
      w_clr[r_evt_id] = 1'b1;
    end else begin
      w_clr = '0;
    end
  end

  // Round-robin search: first pending bit at or after the pointer, wrapping.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    w_found    = 1'b0;
    w_grant_id = '0;
    v_idx      = '0;
    for (int k = 0; k < N; k++) begin
      v_idx = {1'b0, r_ptr} + IDX_W'(k);
      if (v_idx >= N_W) begin
        v_idx = v_idx - N_W;
      end else begin
        v_idx = v_idx;
      end
      if (!w_found && r_pending[v_idx[IDW-1:0]]) begin
        w_found    = 1'b1;
        w_grant_id = v_idx[IDW-1:0];
      end else begin
        w_found    = w_found;
      end
    end
  end

  // Pointer moves to the button just after the one delivered, wrapping at N.
  always_comb begin
    logic [IDX_W-1:0] v_nxt;
    v_nxt = {1'b0, r_evt_id} + IDX_W'(1);
    if (v_nxt >= N_W) begin
      v_nxt = v_nxt - N_W;
    end else begin
      v_nxt = v_nxt;
    end
    w_next_ptr = v_nxt[IDW-1:0];
  end

  // Input sampling and per-button debounce counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s  <= '0;
      r_db <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= 8'd0;
      end
    end else begin
      r_s <= i_button;
      for (int i = 0; i < N; i++) begin
        if (r_s[i] == r_db[i]) begin
          r_cnt[i] <= 8'd0;
        end else if (r_cnt[i] != CNT_MAX) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end else begin
          r_db[i]  <= r_s[i];
          r_cnt[i] <= 8'd0;
        end
      end
    end
  end

  // Toggle, pending and sticky overflow bookkeeping; a rise beats a same-edge clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_toggle   <= '0;
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_toggle   <= r_toggle ^ w_rise;
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      r_overflow <= r_overflow | (w_rise & r_pending & ~w_clr);
    end
  end

  // Arbiter FSM: offer one granted button, hold it until the consumer accepts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_ptr       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_evt_id    <= w_grant_id;
            r_evt_valid <= 1'b1;
            r_state     <= ST_OFFER;
          end else begin
            r_evt_valid <= 1'b0;
          end
        end
        ST_OFFER: begin
          if (i_evt_ready) begin
            r_evt_valid <= 1'b0;
            r_ptr       <= w_next_ptr;
            r_state     <= ST_IDLE;
          end else begin
            r_evt_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_evt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_evt_valid    = r_evt_valid;
  assign o_evt_id       = r_evt_id;
  assign o_toggle_state = r_toggle;
  assign o_pending      = r_pending;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (N=4, DEBOUNCE=3).
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] button;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] toggle_state;
  logic [3:0] pending;
  logic [3:0] overflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       rdy;
    logic       v;
    logic [1:0] id;
    logic [3:0] tog;
    logic [3:0] pend;
    logic [3:0] ov;
    string      name;
  } vec_t;

  vec_t vecs[$];

  button_event_arbiter #(.N(4), .IDW(2), .DEBOUNCE(3)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_button       (button),
    .i_evt_ready    (evt_ready),
    .o_evt_valid    (evt_valid),
    .o_evt_id       (evt_id),
    .o_toggle_state (toggle_state),
    .o_pending      (pending),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] b, input logic rd, input logic v,
                     input logic [1:0] id, input logic [3:0] tg, input logic [3:0] pd,
                     input logic [3:0] ov, input string nm);
    vec_t e;
    e.rst = r; e.btn = b; e.rdy = rd; e.v = v; e.id = id;
    e.tog = tg; e.pend = pd; e.ov = ov; e.name = nm;
    vecs.push_back(e);
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic apply(input logic r, input logic [3:0] b, input logic rd);
    rst = r; button = b; evt_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic v, input logic [1:0] id,
                       input logic [3:0] tg, input logic [3:0] pd, input logic [3:0] ov);
    n_checks++;
    if (evt_valid !== v) begin
      n_errors++;
      $display("FAIL %s evt_valid got %b want %b", nm, evt_valid, v);
    end
    if (v) begin
      n_checks++;
      if (evt_id !== id) begin
        n_errors++;
        $display("FAIL %s evt_id got %0d want %0d", nm, evt_id, id);
      end
    end
    n_checks++;
    if (toggle_state !== tg) begin
      n_errors++;
      $display("FAIL %s toggle_state got %b want %b", nm, toggle_state, tg);
    end
    n_checks++;
    if (pending !== pd) begin
      n_errors++;
      $display("FAIL %s pending got %b want %b", nm, pending, pd);
    end
    n_checks++;
    if (overflow !== ov) begin
      n_errors++;
      $display("FAIL %s overflow got %b want %b", nm, overflow, ov);
    end
  endtask

  initial begin
    rst = 1'b1; button = 4'b0000; evt_ready = 1'b0;

    // reset state
    add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, "reset0");
    add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, "reset1");
    // single press of button 0, consumer always ready
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, "b0_settle");
    add(1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0001, 4'b0000, "b0_edge3");
    add(1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001, 4'b0000, "b0_offer");
    add(1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000, "b0_hs");
    add(1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000, "b0_gap");
    for (int k = 0; k < 4; k++)
      add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000, "b0_release");
    // two-edge glitch on button 2 must be rejected
    for (int k = 0; k < 2; k++)
      add(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000, "glitch_hi");
    for (int k = 0; k < 4; k++)
      add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000, "glitch_lo");
    // round robin over 1011
    add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, "rr_reset0");
    add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, "rr_reset1");
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, "rr_settle");
    add(1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011, 4'b1011, 4'b0000, "rr_rise");
    add(1'b0, 4'b1011, 1'b1, 1'b1, 2'd0, 4'b1011, 4'b1011, 4'b0000, "rr_offer0");
    add(1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011, 4'b1010, 4'b0000, "rr_hs0");
    add(1'b0, 4'b1011, 1'b1, 1'b1, 2'd1, 4'b1011, 4'b1010, 4'b0000, "rr_offer1");
    add(1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011, 4'b1000, 4'b0000, "rr_hs1");
    add(1'b0, 4'b1011, 1'b1, 1'b1, 2'd3, 4'b1011, 4'b1000, 4'b0000, "rr_offer3");
    add(1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011, 4'b0000, 4'b0000, "rr_hs3");
    for (int k = 0; k < 4; k++)
      add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1011, 4'b0000, 4'b0000, "rr_release");
    // pointer wrapped to 0: buttons 0 and 1 again
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b1011, 4'b0000, 4'b0000, "rr2_settle");
    add(1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b1000, 4'b0011, 4'b0000, "rr2_rise");
    add(1'b0, 4'b0011, 1'b1, 1'b1, 2'd0, 4'b1000, 4'b0011, 4'b0000, "rr2_offer0");
    add(1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b1000, 4'b0010, 4'b0000, "rr2_hs0");
    add(1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 4'b1000, 4'b0010, 4'b0000, "rr2_offer1");
    add(1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b1000, 4'b0000, 4'b0000, "rr2_hs1");
    add(1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b1000, 4'b0000, 4'b0000, "rr2_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].btn, vecs[i].rdy);
      check(vecs[i].name, vecs[i].v, vecs[i].id, vecs[i].tog, vecs[i].pend, vecs[i].ov);
    end

    // Backpressure: button 1 held offered for 10 cycles, then one handshake.
    apply(1'b1, 4'b0000, 1'b0);
    apply(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) apply(1'b0, 4'b0010, 1'b0);
    check("bp_rise", 1'b0, 2'd0, 4'b0010, 4'b0010, 4'b0000);
    apply(1'b0, 4'b0010, 1'b0);
    check("bp_offer", 1'b1, 2'd1, 4'b0010, 4'b0010, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 4'b0010, 1'b0);
      check("bp_hold", 1'b1, 2'd1, 4'b0010, 4'b0010, 4'b0000);
    end
    apply(1'b0, 4'b0010, 1'b1);
    check("bp_hs", 1'b0, 2'd0, 4'b0010, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 4'b0010, 1'b1);
      check("bp_single", 1'b0, 2'd0, 4'b0010, 4'b0000, 4'b0000);
    end

    // Overflow: button 3 pressed twice before delivery.
    apply(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) apply(1'b0, 4'b1000, 1'b0);
    check("ov_first", 1'b0, 2'd0, 4'b1000, 4'b1000, 4'b0000);
    apply(1'b0, 4'b0000, 1'b0);
    check("ov_offer", 1'b1, 2'd3, 4'b1000, 4'b1000, 4'b0000);
    for (int k = 0; k < 3; k++) apply(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) apply(1'b0, 4'b1000, 1'b0);
    check("ov_second", 1'b1, 2'd3, 4'b0000, 4'b1000, 4'b1000);
    apply(1'b0, 4'b1000, 1'b1);
    check("ov_hs", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 4'b1000, 1'b1);
      check("ov_one_event", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b1000);
    end
    apply(1'b1, 4'b0000, 1'b0);
    check("ov_rst_clear", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);

    // Rise and handshake on the same button at the same edge: rise wins.
    for (int k = 0; k < 4; k++) apply(1'b0, 4'b0100, 1'b0);
    apply(1'b0, 4'b0000, 1'b0);
    check("sim_offer", 1'b1, 2'd2, 4'b0100, 4'b0100, 4'b0000);
    for (int k = 0; k < 3; k++) apply(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) apply(1'b0, 4'b0100, 1'b0);
    apply(1'b0, 4'b0100, 1'b1);
    check("sim_rise_wins", 1'b0, 2'd0, 4'b0000, 4'b0100, 4'b0000);
    apply(1'b0, 4'b0100, 1'b0);
    check("sim_reoffer", 1'b1, 2'd2, 4'b0000, 4'b0100, 4'b0000);
    apply(1'b0, 4'b0100, 1'b1);
    check("sim_hs", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);

    // Reset in the middle of an offer with button 0 held.
    apply(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) apply(1'b0, 4'b0001, 1'b0);
    check("mid_offer", 1'b1, 2'd0, 4'b0001, 4'b0001, 4'b0000);
    apply(1'b1, 4'b0001, 1'b0);
    check("mid_rst", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'b0001, 1'b0);
      check("mid_settle", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);
    end
    apply(1'b0, 4'b0001, 1'b0);
    check("mid_rise", 1'b0, 2'd0, 4'b0001, 4'b0001, 4'b0000);
    apply(1'b0, 4'b0001, 1'b0);
    check("mid_reoffer", 1'b1, 2'd0, 4'b0001, 4'b0001, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
